seq_mult_8bit: RTL and testbench
================================

Name: seq_mult_8bit

Overview:
Iterative 8x8 multiplier that sits directly upstream of the team's 8-bit carry-lookahead adder and drives its A/B/C_in inputs once per cycle. The adder's S, Cout and Ovfl outputs are consumed on the same cycle.
- Unsigned operands use a radix-2 shift-add scheme.
- Signed operands use radix-2 Booth recoding.
- The block delivers a 16-bit product after a fixed 8-step run. It serves the ALU's multiply instruction and the datapath's multi-cycle operation path.

Parameters:
- WIDTH, 8, operand width. Fixed at 8 to match the single internal 8-bit CLA instance; any other value is unsupported.
- STEPS, 8, iteration count. Must equal WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- sgn  input  1  1 = two's-complement operands (Booth); 0 = unsigned; latched with start
- mcand  input  8  multiplicand M; latched with start
- mplier  input  8  multiplier Q; latched with start
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse when prod is valid
- prod  output  16  product {A,Q}; held until the next accepted start
- ovfl  output  1  product does not fit in 8 bits; valid with done, held with prod

Behaviour:
- Reset (rst=1 at an edge), including mid-operation:
  - state goes to IDLE; A, Q, q_m1 (Booth extra bit) and the step counter clear to 0.
  - busy=0, done=0, prod=0, ovfl=0.
  - Any in-flight operation is discarded.
- States:
  - IDLE: busy=0. When start=1, latch M, Q, sgn; clear A=0 and q_m1=0; clear count=0; go to RUN.
  - RUN: busy=1. One step per cycle. count increments each step. After the step at count=7, go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- start during RUN or DONE is ignored; it is not queued.
- start is accepted in IDLE on the same edge as the return from DONE only if start=1 in the IDLE cycle itself.
- Latency: start sampled at edge k, steps occur at edges k+1..k+8, done is high in the cycle after edge k+8. Back-to-back operation costs 10 cycles per multiply.
- Unsigned step (sgn=0):
  - If Q[0]=1, drive the adder with A, M, C_in=0; new shift-in bit = Cout, sum = S.
  - Else sum = A, shift-in = 0.
  - Then {A,Q} <= {shift-in, sum, Q[7:1]}.
- Signed step (sgn=1), keyed on {Q[0], q_m1}:
  - 01: adder A+M, C_in=0.
  - 10: adder A+~M, C_in=1.
  - 00/11: sum = A, no add.
- Signed sign bit and shift:
  - Shift-in = sum[7] XOR (Ovfl when an add/sub occurred, else 0). This corrects M=-128 and other overflow cases.
  - Then {A,Q,q_m1} <= {shift-in, sum, Q}, i.e. arithmetic right shift by one.
- The adder is always driven; its outputs are ignored on no-add steps and outside RUN.
- prod = {A,Q} registered. prod changes only during RUN, and is stable from done until the next accepted start.
- ovfl, computed at the final step:
  - unsigned: prod[15:8] != 0.
  - signed: prod[15:8] != {8{prod[7]}}.
- Zero operands need no special handling and complete in the full 8 steps; there is no early termination.

Test Plan:
- sgn=0, mcand=0x0C, mplier=0x0A, start 1 cycle -> busy high 8 cycles, done pulse in the cycle after edge k+8, prod=0x0078, ovfl=0.
- sgn=0, 0xFF*0xFF -> prod=0xFE01, ovfl=1. Then 0x00*0xFF -> prod=0x0000, ovfl=0, same 8-step latency.
- sgn=1, 0xFD(-3)*0x05 -> prod=0xFFF1, ovfl=0. Also 0x7F*0x80 -> prod=0xC080, ovfl=1.
- sgn=1, 0x80*0x80 (exercises the Ovfl shift-in correction) -> prod=0x4000, ovfl=1. Also 0x80*0x01 -> prod=0xFF80, ovfl=0.
- Start 0x03*0x04; assert start again with 0xFF*0xFF at cycles 3 and at the DONE cycle -> second request ignored, prod=0x000C, one done pulse, prod held until a new IDLE start.
- Start 0xFF*0xFF, assert rst at step 4 -> next cycle busy=0, done=0, prod=0x0000, ovfl=0, no done pulse. A subsequent 0x02*0x03 run -> prod=0x0006.

Source files
------------

// File: rtl/seq_mult_8bit.sv
// Iterative 8x8 multiplier: one shift/add step per cycle through a single
// 8-bit carry-lookahead adder. Unsigned operands use radix-2 shift-add,
// signed operands use radix-2 Booth recoding. A run is 8 steps long.

// 8-bit carry-lookahead adder with carry-out and signed-overflow flag.
module cla_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c_in,
    output logic [7:0] s,
    output logic       cout,
    output logic       ovfl
);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    assign c[0] = c_in;

    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
        logic carry_term;

        assign g[gi] = a[gi] & b[gi];
        assign p[gi] = a[gi] ^ b[gi];

        // Each carry is expanded from the generate/propagate terms of all lower bits.
        always_comb begin
            carry_term = c_in;
            for (int j = 0; j <= gi; j++) begin
                carry_term = g[j] | (p[j] & carry_term);
            end
        end

        assign c[gi+1] = carry_term;
        assign s[gi]   = p[gi] ^ c[gi];
    end

    assign cout = c[8];
    assign ovfl = c[8] ^ c[7];
endmodule

module seq_mult_8bit #(
    parameter int WIDTH = 8,
    parameter int STEPS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 ovfl
);
    localparam int CW = $clog2(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH-1:0]   m_reg;
    logic               q_m1_reg;
    logic               sgn_reg;
    logic [CW-1:0]      count_reg;
    logic [2*WIDTH-1:0] prod_reg;
    logic               ovfl_reg;

    // Adder interface and step results
    logic [WIDTH-1:0]   add_b;
    logic               add_cin;
    logic [WIDTH-1:0]   add_s;
    logic               add_cout;
    logic               add_ovfl;
    logic               do_add;
    logic [WIDTH-1:0]   sum;
    logic               shift_in;
    logic [WIDTH-1:0]   a_next;
    logic [WIDTH-1:0]   q_next;
    logic [2*WIDTH-1:0] prod_next;
    logic               ovfl_next;
    logic               last_step;

    // The adder is always driven; its result is only used on add/sub steps.
    cla_8bit u_cla (
        .a    (a_reg),
        .b    (add_b),
        .c_in (add_cin),
        .s    (add_s),
        .cout (add_cout),
        .ovfl (add_ovfl)
    );

    // Step decode: pick the adder operand, then form the shifted {A,Q}.
    always_comb begin
        do_add  = 1'b0;
        add_b   = m_reg;
        add_cin = 1'b0;
        if (sgn_reg) begin
            unique case ({q_reg[0], q_m1_reg})
                2'b01: do_add = 1'b1;
                2'b10: begin
                    do_add  = 1'b1;
                    add_b   = ~m_reg;
                    add_cin = 1'b1;
                end
                default: do_add = 1'b0;
            endcase
        end else begin
            do_add = q_reg[0];
        end

        sum = do_add ? add_s : a_reg;

        // Signed: true sign of the 9-bit result, which fixes the case where
        // the 8-bit sum overflowed (e.g. subtracting M=-128).
        if (sgn_reg) begin
            shift_in = sum[WIDTH-1] ^ (do_add & add_ovfl);
        end else begin
            shift_in = do_add & add_cout;
        end

        a_next    = {shift_in, sum[WIDTH-1:1]};
        q_next    = {sum[0], q_reg[WIDTH-1:1]};
        prod_next = {a_next, q_next};

        if (sgn_reg) begin
            ovfl_next = (prod_next[2*WIDTH-1:WIDTH] != {WIDTH{prod_next[WIDTH-1]}});
        end else begin
            ovfl_next = (prod_next[2*WIDTH-1:WIDTH] != '0);
        end
    end

    assign last_step = (state_reg == S_RUN) && (count_reg == LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (count_reg == LAST) state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: latch operands on accepted start, iterate in RUN, capture
    // the product and overflow flag on the final step.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            q_reg     <= '0;
            m_reg     <= '0;
            q_m1_reg  <= 1'b0;
            sgn_reg   <= 1'b0;
            count_reg <= '0;
            prod_reg  <= '0;
            ovfl_reg  <= 1'b0;
        end else begin
            if (state_reg == S_IDLE && start) begin
                a_reg     <= '0;
                q_reg     <= mplier;
                m_reg     <= mcand;
                q_m1_reg  <= 1'b0;
                sgn_reg   <= sgn;
                count_reg <= '0;
            end else if (state_reg == S_RUN) begin
                a_reg     <= a_next;
                q_reg     <= q_next;
                q_m1_reg  <= q_reg[0];
                count_reg <= count_reg + CW'(1);
            end
            if (last_step) begin
                prod_reg <= prod_next;
                ovfl_reg <= ovfl_next;
            end
        end
    end

    assign prod = prod_reg;
    assign ovfl = ovfl_reg;
endmodule

// File: tb/tb_seq_mult_8bit.sv
// Scoreboard bench for seq_mult_8bit: stimulus pushes expected results
// computed with plain integer arithmetic; a monitor checks each done pulse.
module tb_seq_mult_8bit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [7:0]  mcand;
    logic [7:0]  mplier;
    logic        busy;
    logic        done;
    logic [15:0] prod;
    logic        ovfl;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] prod;
        logic        ovfl;
        int          cyc;
        logic        s;
        logic [7:0]  m;
        logic [7:0]  q;
    } exp_t;

    exp_t sb[$];

    seq_mult_8bit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sgn    (sgn),
        .mcand  (mcand),
        .mplier (mplier),
        .busy   (busy),
        .done   (done),
        .prod   (prod),
        .ovfl   (ovfl)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: full-precision integer product.
    function automatic exp_t model(logic s, logic [7:0] m, logic [7:0] q, int c);
        exp_t e;
        int p;
        if (s) p = int'($signed(m)) * int'($signed(q));
        else   p = int'(m) * int'(q);
        e.prod = 16'(p);
        e.ovfl = s ? ((p < -128) || (p > 127)) : (p > 255);
        e.cyc  = c;
        e.s    = s;
        e.m    = m;
        e.q    = q;
        return e;
    endfunction

    // Called at a negedge; start is sampled at the following posedge.
    task automatic issue(logic s, logic [7:0] m, logic [7:0] q, logic push);
        sgn    = s;
        mcand  = m;
        mplier = q;
        start  = 1'b1;
        if (push) sb.push_back(model(s, m, q, cyc + 9));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && (busy || done); i++) @(negedge clk);
        chk("idle_timeout", {30'd0, busy, done}, 32'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic run_op(logic s, logic [7:0] m, logic [7:0] q);
        wait_idle();
        issue(s, m, q, 1'b1);
        wait_done();
        @(negedge clk);
    endtask

    // Monitor: pops one expectation per done pulse and checks result, latency
    // and busy duration; any done with nothing outstanding is an error.
    initial begin
        int   busy_run = 0;
        logic done_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy) busy_run++;
            else if (!done) busy_run = 0;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    $display("txn sgn=%0d m=%h q=%h prod=%h ovfl=%0d (want %h/%0d) cyc=%0d",
                             e.s, e.m, e.q, prod, ovfl, e.prod, e.ovfl, cyc);
                    chk("prod", {16'd0, prod}, {16'd0, e.prod});
                    chk("ovfl", {31'd0, ovfl}, {31'd0, e.ovfl});
                    chk("latency", cyc, e.cyc);
                    chk("busy_cycles", busy_run, 32'd8);
                end
                chk("done_single", {31'd0, done_prev}, 32'd0);
                busy_run = 0;
            end
            done_prev = done;
        end
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        sgn    = 1'b0;
        mcand  = 8'h00;
        mplier = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_prod", {16'd0, prod}, 32'd0);
        chk("rst_ovfl", {31'd0, ovfl}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op(1'b0, 8'h0C, 8'h0A);
        run_op(1'b0, 8'hFF, 8'hFF);
        run_op(1'b0, 8'h00, 8'hFF);
        run_op(1'b1, 8'hFD, 8'h05);
        run_op(1'b1, 8'h7F, 8'h80);
        run_op(1'b1, 8'h80, 8'h80);
        run_op(1'b1, 8'h80, 8'h01);
        run_op(1'b1, 8'h00, 8'h00);
        run_op(1'b1, 8'hFF, 8'hFF);

        // Starts during RUN and DONE must be ignored
        wait_idle();
        issue(1'b0, 8'h03, 8'h04, 1'b1);
        repeat (2) @(negedge clk);
        issue(1'b0, 8'hFF, 8'hFF, 1'b0);
        wait_done();
        sgn = 1'b0; mcand = 8'hFF; mplier = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("held_prod", {16'd0, prod}, 32'h000C);
        chk("held_ovfl", {31'd0, ovfl}, 32'd0);
        chk("held_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of a run discards it
        wait_idle();
        issue(1'b0, 8'hFF, 8'hFF, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_prod", {16'd0, prod}, 32'd0);
        chk("midrst_ovfl", {31'd0, ovfl}, 32'd0);
        repeat (12) @(negedge clk);
        run_op(1'b0, 8'h02, 8'h03);

        // Randomized operands, both modes
        for (int i = 0; i < 60; i++) begin
            run_op(1'(i % 2), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        repeat (15) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
